// File: rtl/mux64_scan_seq_if.sv
// Handshake and mux-bus bundle for mux64_scan_seq.
// slave = sequencer side, master = producer/consumer/mux side.
interface mux64_scan_seq_if #(
  parameter int SEL_W = 6
);
  localparam int N = 2 ** SEL_W;

  logic [N-1:0]     word_in;
  logic [SEL_W-1:0] start_idx;
  logic [SEL_W-1:0] end_idx;
  logic             word_valid;
  logic             word_ready;
  logic [N-1:0]     mux_in;
  logic [SEL_W-1:0] mux_select;
  logic             mux_out;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_last;
  logic             busy;

  modport slave (
    input  word_in, start_idx, end_idx, word_valid,
    input  mux_out, bit_ready,
    output word_ready, mux_in, mux_select,
    output bit_out, bit_valid, bit_last, busy
  );

  modport master (
    output word_in, start_idx, end_idx, word_valid,
    output mux_out, bit_ready,
    input  word_ready, mux_in, mux_select,
    input  bit_out, bit_valid, bit_last, busy
  );
endinterface

// File: rtl/mux64_scan_seq.sv
// Word-to-serial scan sequencer driving an external N:1 bit mux.
// MUX64_SCAN_PARITY_EN adds a trailing parity beat after the data bits.
module mux64_scan_seq #(
  parameter int SEL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  mux64_scan_seq_if.slave   bus
);
  localparam int N = 2 ** SEL_W;

`ifdef MUX64_SCAN_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_PAR  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [N-1:0]     mux_in_q, mux_in_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] end_q, end_d;
  logic             at_end;
  logic             hs;
`ifdef MUX64_SCAN_PARITY_EN
  logic             par_q, par_d;
`endif

  assign at_end = (sel_q == end_q);
  assign hs     = bus.bit_valid && bus.bit_ready;

  always_comb begin
    state_d        = state_q;
    mux_in_d       = mux_in_q;
    sel_d          = sel_q;
    end_d          = end_q;
`ifdef MUX64_SCAN_PARITY_EN
    par_d          = par_q;
`endif
    bus.word_ready = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_last   = 1'b0;
    bus.bit_out    = 1'b0;
    bus.busy       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.word_ready = 1'b1;
        if (bus.word_valid) begin
          mux_in_d = bus.word_in;
          sel_d    = bus.start_idx;
          end_d    = bus.end_idx;
`ifdef MUX64_SCAN_PARITY_EN
          par_d    = 1'b0;
`endif
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        bus.bit_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.bit_out   = bus.mux_out;
`ifdef MUX64_SCAN_PARITY_EN
        if (hs) begin
          par_d = par_q ^ bus.mux_out;
          if (at_end) state_d = S_PAR;
          else        sel_d   = sel_q + SEL_W'(1);
        end
`else
        bus.bit_last = at_end;
        if (hs) begin
          if (at_end) state_d = S_IDLE;
          else        sel_d   = sel_q + SEL_W'(1);
        end
`endif
      end
`ifdef MUX64_SCAN_PARITY_EN
      S_PAR: begin
        bus.bit_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.bit_last  = 1'b1;
        bus.bit_out   = par_q;
        if (hs) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mux_in_q <= '0;
      sel_q    <= '0;
      end_q    <= '0;
`ifdef MUX64_SCAN_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mux_in_q <= mux_in_d;
      sel_q    <= sel_d;
      end_q    <= end_d;
`ifdef MUX64_SCAN_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.mux_in     = mux_in_q;
  assign bus.mux_select = sel_q;
endmodule

// File: tb/tb_mux64_scan_seq.sv
// Directed bench for mux64_scan_seq with a behavioural 64:1 mux on the return path.
// Beat expectations are hand-packed: bit k of exp_bits is the k-th emitted data bit.
module tb_mux64_scan_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mux64_scan_seq_if #(.SEL_W(6)) bus ();

  mux64_scan_seq #(.SEL_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mux_out = bus.mux_in[bus.mux_select];

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] word;
    logic [5:0]  s;
    logic [5:0]  e;
    int          n;
    logic [63:0] bits;
    bit          hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with beat k0 on the bus and bit_ready=1.
  task automatic run_beats(input int id, input logic [63:0] bits,
                           input int s, input int n, input int k0);
    for (int k = k0; k < n; k++) begin
      chk($sformatf("t%0d_valid%0d", id, k), 64'(bus.bit_valid), 64'd1);
      chk($sformatf("t%0d_bit%0d", id, k), 64'(bus.bit_out), 64'(bits[k]));
      chk($sformatf("t%0d_sel%0d", id, k), 64'(bus.mux_select),
          64'((s + k) % 64));
`ifdef MUX64_SCAN_PARITY_EN
      chk($sformatf("t%0d_last%0d", id, k), 64'(bus.bit_last), 64'd0);
`else
      chk($sformatf("t%0d_last%0d", id, k), 64'(bus.bit_last),
          64'(k == n - 1));
`endif
      @(negedge clk);
    end
`ifdef MUX64_SCAN_PARITY_EN
    chk($sformatf("t%0d_par_valid", id), 64'(bus.bit_valid), 64'd1);
    chk($sformatf("t%0d_par_bit", id), 64'(bus.bit_out), 64'(^bits));
    chk($sformatf("t%0d_par_last", id), 64'(bus.bit_last), 64'd1);
    @(negedge clk);
`endif
    chk($sformatf("t%0d_end_valid", id), 64'(bus.bit_valid), 64'd0);
    chk($sformatf("t%0d_end_ready", id), 64'(bus.word_ready), 64'd1);
    chk($sformatf("t%0d_end_busy", id), 64'(bus.busy), 64'd0);
  endtask

  task automatic accept(input int id, input vec_t v);
    bus.word_in    = v.word;
    bus.start_idx  = v.s;
    bus.end_idx    = v.e;
    bus.word_valid = 1'b1;
    bus.bit_ready  = 1'b1;
    chk($sformatf("t%0d_acc_ready", id), 64'(bus.word_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if (v.hold) begin
      bus.word_in   = ~v.word;
      bus.start_idx = v.s + 6'd3;
      bus.end_idx   = v.s;
    end else begin
      bus.word_valid = 1'b0;
    end
  endtask

  task automatic scan(input int id, input vec_t v);
    accept(id, v);
    run_beats(id, v.bits, int'(v.s), v.n, 0);
    bus.word_valid = 1'b0;
    chk($sformatf("t%0d_mux_in_held", id), bus.mux_in, v.word);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{64'hA5, 6'd0, 6'd7, 8, 64'hA5, 1'b0};
    vecs[1] = '{64'hC000_0000_0000_0003, 6'd62, 6'd1, 4, 64'hF, 1'b0};
    vecs[2] = '{64'h400, 6'd10, 6'd10, 1, 64'h1, 1'b0};
    vecs[3] = '{64'h1, 6'd5, 6'd4, 64, 64'h0800_0000_0000_0000, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 6'd63, 6'd63, 1, 64'h1, 1'b0};
    vecs[5] = '{64'h5000_0000_0000_000A, 6'd60, 6'd3, 8, 64'hA5, 1'b1};
    vecs[6] = '{64'h7, 6'd0, 6'd3, 4, 64'h7, 1'b0};

    bus.word_in    = '0;
    bus.start_idx  = '0;
    bus.end_idx    = '0;
    bus.word_valid = 1'b0;
    bus.bit_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_word_ready", 64'(bus.word_ready), 64'd1);
    chk("rst_bit_valid", 64'(bus.bit_valid), 64'd0);
    chk("rst_bit_last", 64'(bus.bit_last), 64'd0);
    chk("rst_mux_select", 64'(bus.mux_select), 64'd0);
    chk("rst_mux_in", bus.mux_in, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) scan(i, vecs[i]);

    // Stall: bit_ready pattern 1,0,0,1 across beats 0 and 1.
    v = vecs[0];
    accept(10, v);
    chk("stall_b0_sel", 64'(bus.mux_select), 64'd0);
    chk("stall_b0_bit", 64'(bus.bit_out), 64'd1);
    @(negedge clk);
    bus.bit_ready = 1'b0;
    chk("stall_b1_sel", 64'(bus.mux_select), 64'd1);
    chk("stall_b1_bit", 64'(bus.bit_out), 64'd0);
    @(negedge clk);
    chk("stall_hold_sel", 64'(bus.mux_select), 64'd1);
    chk("stall_hold_bit", 64'(bus.bit_out), 64'd0);
    chk("stall_hold_valid", 64'(bus.bit_valid), 64'd1);
    @(negedge clk);
    chk("stall_hold2_sel", 64'(bus.mux_select), 64'd1);
    chk("stall_hold2_last", 64'(bus.bit_last), 64'd0);
    bus.bit_ready = 1'b1;
    run_beats(11, v.bits, 0, v.n, 1);

    // Reset during beat 3 of an 8-bit scan.
    accept(20, v);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_sel", 64'(bus.mux_select), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(bus.bit_valid), 64'd0);
    chk("abort_last", 64'(bus.bit_last), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_ready", 64'(bus.word_ready), 64'd1);
    chk("abort_sel", 64'(bus.mux_select), 64'd0);
    chk("abort_mux_in", bus.mux_in, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    scan(21, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
